// File: rtl/video_timing_pkg.sv
// Mode constant sets for the raster timing generators.
// Each mode lists its horizontal/vertical region widths and sync polarities.
package video_timing_pkg;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
        bit          hsync_pol;
        bit          vsync_pol;
    } video_mode_t;

    localparam video_mode_t XVGA_1024x768_60 = '{
        h_active: 1024, h_fp: 24, h_sync: 136, h_bp: 160,
        v_active: 768,  v_fp: 3,  v_sync: 6,   v_bp: 29,
        hsync_pol: 1'b0, vsync_pol: 1'b0
    };

    localparam video_mode_t VGA_640x480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
        hsync_pol: 1'b0, vsync_pol: 1'b0
    };

endpackage

// File: rtl/sync_delay.sv
// WIDTH x DEPTH shift register that reloads RESET_VALUE into every stage on reset.
// taps[0] is the undelayed input, taps[k] is the input from k cycles earlier.
module sync_delay #(
    parameter int unsigned       WIDTH       = 3,
    parameter int unsigned       DEPTH       = 1,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [WIDTH-1:0]            din,
    output logic [DEPTH:0][WIDTH-1:0]   taps
);

    logic [DEPTH-1:0][WIDTH-1:0] stage;

    always_ff @(posedge clk) begin
        if (reset) begin
            stage <= {DEPTH{RESET_VALUE}};
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign taps = {stage, din};

endmodule

// File: rtl/xvga_timing_gen.sv
// Parametrised raster timing generator with registered sync/blank, start strobes
// and a PIPE_DEPTH delay line that drives the VGA DAC pins.
module xvga_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = XVGA_1024x768_60.h_active,
    parameter int unsigned H_FP       = XVGA_1024x768_60.h_fp,
    parameter int unsigned H_SYNC     = XVGA_1024x768_60.h_sync,
    parameter int unsigned H_BP       = XVGA_1024x768_60.h_bp,
    parameter int unsigned V_ACTIVE   = XVGA_1024x768_60.v_active,
    parameter int unsigned V_FP       = XVGA_1024x768_60.v_fp,
    parameter int unsigned V_SYNC     = XVGA_1024x768_60.v_sync,
    parameter int unsigned V_BP       = XVGA_1024x768_60.v_bp,
    parameter logic        HSYNC_POL  = XVGA_1024x768_60.hsync_pol,
    parameter logic        VSYNC_POL  = XVGA_1024x768_60.vsync_pol,
    parameter int unsigned PIPE_DEPTH = 1,
    parameter int unsigned HW         = 11,
    parameter int unsigned VW         = 10
) (
    input  logic          vclock,
    input  logic          reset,
    output logic [HW-1:0] hcount,
    output logic [VW-1:0] vcount,
    output logic          hsync,
    output logic          vsync,
    output logic          blank,
    output logic          frame_start,
    output logic          line_start,
    input  logic [23:0]   pixel_in,
    output logic          phsync,
    output logic          pvsync,
    output logic          pblank,
    output logic [23:0]   pixel_out
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam logic [2:0]  IDLE     = {~HSYNC_POL, ~VSYNC_POL, 1'b1};

    if (H_TOTAL > (32'd1 << HW)) begin : g_hw_too_small
        $error("H_TOTAL does not fit in HW bits");
    end
    if (V_TOTAL > (32'd1 << VW)) begin : g_vw_too_small
        $error("V_TOTAL does not fit in VW bits");
    end
    if (PIPE_DEPTH < 1 || PIPE_DEPTH > 8) begin : g_bad_depth
        $error("PIPE_DEPTH must be in 1..8");
    end

    logic          h_wrap;
    logic [HW-1:0] h_next;
    logic [VW-1:0] v_next;

    always_comb begin
        h_wrap = (32'(hcount) == H_TOTAL - 1);
        h_next = h_wrap ? '0 : hcount + 1'b1;
        v_next = vcount;
        if (h_wrap) begin
            v_next = (32'(vcount) == V_TOTAL - 1) ? '0 : vcount + 1'b1;
        end
    end

    // Sync and blank are decoded from the next-count values so they land on
    // the same edge as the counters they describe.
    always_ff @(posedge vclock) begin
        if (reset) begin
            hcount <= '0;
            vcount <= '0;
            hsync  <= ~HSYNC_POL;
            vsync  <= ~VSYNC_POL;
            blank  <= 1'b0;
        end else begin
            hcount <= h_next;
            vcount <= v_next;
            hsync  <= (32'(h_next) >= HS_START && 32'(h_next) < HS_END) ? HSYNC_POL : ~HSYNC_POL;
            vsync  <= (32'(v_next) >= VS_START && 32'(v_next) < VS_END) ? VSYNC_POL : ~VSYNC_POL;
            blank  <= (32'(h_next) >= H_ACTIVE) || (32'(v_next) >= V_ACTIVE);
        end
    end

    assign line_start  = !reset && (hcount == '0);
    assign frame_start = !reset && (hcount == '0) && (vcount == '0);

    logic [PIPE_DEPTH:0][2:0] taps;

    sync_delay #(
        .WIDTH       (3),
        .DEPTH       (PIPE_DEPTH),
        .RESET_VALUE (IDLE)
    ) u_sync_delay (
        .clk   (vclock),
        .reset (reset),
        .din   ({hsync, vsync, blank}),
        .taps  (taps)
    );

    assign {phsync, pvsync, pblank} = taps[PIPE_DEPTH];

    // Blanking uses the stage one short of the output so the registered pixel
    // lines up with pblank.
    always_ff @(posedge vclock) begin
        if (reset || taps[PIPE_DEPTH-1][0]) begin
            pixel_out <= '0;
        end else begin
            pixel_out <= pixel_in;
        end
    end

endmodule

// File: tb/tb_xvga_timing_gen.sv
// Bench for xvga_timing_gen: two small-mode instances (pipe depth 1 and 3) and
// one default XVGA instance with active-high hsync.
module tb_xvga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic        reset_a = 1'b1, reset_b = 1'b1, reset_c = 1'b1;
    logic [23:0] pixel_a = '0, pixel_b = '0, pixel_c = '0;

    logic [3:0]  a_hcount;  logic [2:0] a_vcount;
    logic        a_hsync, a_vsync, a_blank, a_frame_start, a_line_start, a_phsync, a_pvsync, a_pblank;
    logic [23:0] a_pixel_out;
    logic [3:0]  b_hcount;  logic [2:0] b_vcount;
    logic        b_hsync, b_vsync, b_blank, b_frame_start, b_line_start, b_phsync, b_pvsync, b_pblank;
    logic [23:0] b_pixel_out;
    logic [10:0] c_hcount;  logic [9:0] c_vcount;
    logic        c_hsync, c_vsync, c_blank, c_frame_start, c_line_start, c_phsync, c_pvsync, c_pblank;
    logic [23:0] c_pixel_out;

    logic [26:0] exp_q[$];
    int a_k = 0;
    int b_k = 0;

    xvga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPE_DEPTH(1), .HW(4), .VW(3)
    ) dut_a (
        .vclock(clk), .reset(reset_a), .hcount(a_hcount), .vcount(a_vcount),
        .hsync(a_hsync), .vsync(a_vsync), .blank(a_blank),
        .frame_start(a_frame_start), .line_start(a_line_start), .pixel_in(pixel_a),
        .phsync(a_phsync), .pvsync(a_pvsync), .pblank(a_pblank), .pixel_out(a_pixel_out)
    );

    xvga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPE_DEPTH(3), .HW(4), .VW(3)
    ) dut_b (
        .vclock(clk), .reset(reset_b), .hcount(b_hcount), .vcount(b_vcount),
        .hsync(b_hsync), .vsync(b_vsync), .blank(b_blank),
        .frame_start(b_frame_start), .line_start(b_line_start), .pixel_in(pixel_b),
        .phsync(b_phsync), .pvsync(b_pvsync), .pblank(b_pblank), .pixel_out(b_pixel_out)
    );

    xvga_timing_gen #(
        .HSYNC_POL(1'b1)
    ) dut_c (
        .vclock(clk), .reset(reset_c), .hcount(c_hcount), .vcount(c_vcount),
        .hsync(c_hsync), .vsync(c_vsync), .blank(c_blank),
        .frame_start(c_frame_start), .line_start(c_line_start), .pixel_in(pixel_c),
        .phsync(c_phsync), .pvsync(c_pvsync), .pblank(c_pblank), .pixel_out(c_pixel_out)
    );

    // Small mode reference: H 8/2/3/3 (total 16), V 4/1/2/1 (total 8), active-low syncs.
    function automatic logic small_hs(int h);
        return !(h >= 10 && h < 13);
    endfunction
    function automatic logic small_vs(int v);
        return !(v >= 5 && v < 7);
    endfunction
    function automatic logic small_bl(int h, int v);
        return (h >= 8) || (v >= 4);
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        logic [37:0] got, exp;
        logic [44:0] got_c, exp_c;
        repeat (3) @(posedge clk);
        #2;
        got = {a_hcount, a_vcount, a_hsync, a_vsync, a_blank, a_frame_start, a_line_start,
               a_phsync, a_pvsync, a_pblank, a_pixel_out};
        exp = {4'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 24'd0};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL reset_a: got %h expected %h", got, exp);
        end
        got = {b_hcount, b_vcount, b_hsync, b_vsync, b_blank, b_frame_start, b_line_start,
               b_phsync, b_pvsync, b_pblank, b_pixel_out};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL reset_b: got %h expected %h", got, exp);
        end
        got_c = {c_hcount, c_vcount, c_hsync, c_vsync, c_blank, c_frame_start, c_line_start,
                 c_phsync, c_pvsync, c_pblank, c_pixel_out};
        exp_c = {11'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 24'd0};
        vectors++;
        if (got_c !== exp_c) begin
            miscompares++;
            $display("FAIL reset_c: got %h expected %h", got_c, exp_c);
        end
        @(posedge clk);
        #1 reset_a = 1'b0;
        #1;
        a_k = 0;
        vectors++;
        if ({a_hcount, a_vcount, a_frame_start, a_line_start, a_blank} !== {4'd0, 3'd0, 3'b110}) begin
            miscompares++;
            $display("FAIL first_cycle_a: got h=%0d v=%0d fs=%b ls=%b bl=%b expected h=0 v=0 fs=1 ls=1 bl=0",
                     a_hcount, a_vcount, a_frame_start, a_line_start, a_blank);
        end
    endtask

    task automatic test_hcount_hsync();
        int h;
        repeat (40) begin
            step();
            a_k++;
            h = a_k % 16;
            vectors++;
            if (a_hcount !== 4'(h)) begin
                miscompares++;
                $display("FAIL hcount k=%0d: got %0d expected %0d", a_k, a_hcount, h);
            end
            vectors++;
            if (a_hsync !== small_hs(h)) begin
                miscompares++;
                $display("FAIL hsync h=%0d: got %b expected %b", h, a_hsync, small_hs(h));
            end
        end
    endtask

    task automatic test_vcount_vsync_strobes();
        int h, v;
        int last_fs = -1;
        int last_ls = -1;
        repeat (300) begin
            step();
            a_k++;
            h = a_k % 16;
            v = (a_k / 16) % 8;
            vectors++;
            if (a_vcount !== 3'(v) || a_vsync !== small_vs(v)) begin
                miscompares++;
                $display("FAIL vcount_vsync k=%0d: got v=%0d vs=%b expected v=%0d vs=%b",
                         a_k, a_vcount, a_vsync, v, small_vs(v));
            end
            vectors++;
            if (a_frame_start !== (a_k % 128 == 0) || a_line_start !== (h == 0)) begin
                miscompares++;
                $display("FAIL strobes k=%0d: got fs=%b ls=%b expected fs=%b ls=%b",
                         a_k, a_frame_start, a_line_start, (a_k % 128 == 0), (h == 0));
            end
            if (a_frame_start === 1'b1) begin
                if (last_fs >= 0) begin
                    vectors++;
                    if (a_k - last_fs != 128) begin
                        miscompares++;
                        $display("FAIL frame_period: got %0d expected 128", a_k - last_fs);
                    end
                end
                last_fs = a_k;
            end
            if (a_line_start === 1'b1) begin
                if (last_ls >= 0) begin
                    vectors++;
                    if (a_k - last_ls != 16) begin
                        miscompares++;
                        $display("FAIL line_period: got %0d expected 16", a_k - last_ls);
                    end
                end
                last_ls = a_k;
            end
        end
    endtask

    task automatic test_blank();
        int h, v;
        repeat (128) begin
            step();
            a_k++;
            h = a_k % 16;
            v = (a_k / 16) % 8;
            vectors++;
            if (a_blank !== small_bl(h, v)) begin
                miscompares++;
                $display("FAIL blank h=%0d v=%0d: got %b expected %b", h, v, a_blank, small_bl(h, v));
            end
        end
    endtask

    task automatic test_pipeline();
        logic [26:0] e;
        logic        bl;
        int          h, v;
        pixel_b = 24'hFFFFFF;
        exp_q.delete();
        repeat (3) exp_q.push_back({3'b111, 24'h0});
        @(posedge clk);
        #1 reset_b = 1'b0;
        #1;
        for (int k = 0; k < 300; k++) begin
            if (k > 0) step();
            b_k = k;
            h = k % 16;
            v = (k / 16) % 8;
            bl = small_bl(h, v);
            exp_q.push_back({small_hs(h), small_vs(v), bl, bl ? 24'h0 : 24'hFFFFFF});
            e = exp_q.pop_front();
            vectors++;
            if ({b_phsync, b_pvsync, b_pblank} !== e[26:24] || b_pixel_out !== e[23:0]) begin
                miscompares++;
                $display("FAIL pipe k=%0d: got hs/vs/bl=%b%b%b px=%h expected %b px=%h",
                         k, b_phsync, b_pvsync, b_pblank, b_pixel_out, e[26:24], e[23:0]);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [26:0] e;
        logic        bl;
        int          h, v;
        for (int n = 0; n < 130 && (b_k % 128) != 39; n++) begin
            step();
            b_k++;
        end
        vectors++;
        if (b_hcount !== 4'd7 || b_vcount !== 3'd2) begin
            miscompares++;
            $display("FAIL reset_point: got h=%0d v=%0d expected h=7 v=2", b_hcount, b_vcount);
        end
        reset_b = 1'b1;
        @(posedge clk);
        #1 reset_b = 1'b0;
        #1;
        vectors++;
        if ({b_hcount, b_vcount, b_frame_start} !== {4'd0, 3'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL mid_reset_counters: got h=%0d v=%0d fs=%b expected h=0 v=0 fs=1",
                     b_hcount, b_vcount, b_frame_start);
        end
        exp_q.delete();
        repeat (3) exp_q.push_back({3'b111, 24'h0});
        for (int k = 0; k < 40; k++) begin
            if (k > 0) step();
            h = k % 16;
            v = (k / 16) % 8;
            bl = small_bl(h, v);
            exp_q.push_back({small_hs(h), small_vs(v), bl, bl ? 24'h0 : 24'hFFFFFF});
            e = exp_q.pop_front();
            vectors++;
            if ({b_phsync, b_pvsync, b_pblank} !== e[26:24] || b_pixel_out !== e[23:0]) begin
                miscompares++;
                $display("FAIL mid_reset_pipe k=%0d: got hs/vs/bl=%b%b%b px=%h expected %b px=%h",
                         k, b_phsync, b_pvsync, b_pblank, b_pixel_out, e[26:24], e[23:0]);
            end
        end
    endtask

    task automatic test_default_mode();
        logic [26:0] e;
        logic        hs, bl;
        int          h, v;
        int          last_ls = -1;
        pixel_c = 24'h5AA55A;
        exp_q.delete();
        exp_q.push_back({3'b011, 24'h0});
        @(posedge clk);
        #1 reset_c = 1'b0;
        #1;
        for (int k = 0; k < 3 * 1344 + 20; k++) begin
            if (k > 0) step();
            h = k % 1344;
            v = k / 1344;
            hs = (h >= 1048 && h < 1184);
            bl = (h >= 1024);
            vectors++;
            if (c_hcount !== 11'(h) || c_vcount !== 10'(v)) begin
                miscompares++;
                $display("FAIL default_counters k=%0d: got h=%0d v=%0d expected h=%0d v=%0d",
                         k, c_hcount, c_vcount, h, v);
            end
            vectors++;
            if ({c_hsync, c_vsync, c_blank, c_line_start} !== {hs, 1'b1, bl, (h == 0)}) begin
                miscompares++;
                $display("FAIL default_raw h=%0d: got hs/vs/bl/ls=%b%b%b%b expected %b%b%b%b",
                         h, c_hsync, c_vsync, c_blank, c_line_start, hs, 1'b1, bl, (h == 0));
            end
            exp_q.push_back({hs, 1'b1, bl, bl ? 24'h0 : 24'h5AA55A});
            e = exp_q.pop_front();
            vectors++;
            if ({c_phsync, c_pvsync, c_pblank} !== e[26:24] || c_pixel_out !== e[23:0]) begin
                miscompares++;
                $display("FAIL default_pipe k=%0d: got %b%b%b px=%h expected %b px=%h",
                         k, c_phsync, c_pvsync, c_pblank, c_pixel_out, e[26:24], e[23:0]);
            end
            if (c_line_start === 1'b1) begin
                if (last_ls >= 0) begin
                    vectors++;
                    if (k - last_ls != 1344) begin
                        miscompares++;
                        $display("FAIL default_line_period: got %0d expected 1344", k - last_ls);
                    end
                end
                last_ls = k;
            end
        end
    endtask

    initial begin
        test_reset();
        test_hcount_hsync();
        test_vcount_vsync_strobes();
        test_blank();
        test_pipeline();
        test_mid_reset();
        test_default_mode();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
